buzzer_arbiter: RTL and testbench



---
 rtl/buzzer_arbiter_if.sv | 22 ++
 rtl/buzzer_arbiter.sv | 51 +++++
 tb/tb_buzzer_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/buzzer_arbiter_if.sv
// buzzer_arbiter_if: requester strobes in, buzzer gate and status out
interface buzzer_arbiter_if;
  logic       tick;
  logic       alarm_req;
  logic       chime_req;
  logic       click_req;
  logic       cancel;
  logic       set_mode;
  logic       blink;
  logic       buzz;
  logic       busy;
  logic [1:0] active_src;
  logic       done;
  modport master (
    output tick, alarm_req, chime_req, click_req, cancel, set_mode, blink,
    input  buzz, busy, active_src, done
  );
  modport slave (
    input  tick, alarm_req, chime_req, click_req, cancel, set_mode, blink,
    output buzz, busy, active_src, done
  );
endinterface

// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: fixed-priority buzzer sharing between alarm, chime and key click
module buzzer_arbiter #(
  parameter int ALARM_LEN = 30,
  parameter int CHIME_LEN = 2,
  parameter int CLICK_LEN = 1,
  parameter int CNT_W     = 6
) (
  input logic clk,
  input logic rst_n,
  buzzer_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CLICK, CHIME, ALARM} state_t;
  state_t state, state_n, req;
  logic [CNT_W-1:0] cnt, cnt_n, last;
  logic accept, done, done_n;
  always_comb begin
    req    = bus.alarm_req ? ALARM : bus.chime_req ? CHIME : bus.click_req ? CLICK : IDLE;
    accept = (req != IDLE) && (req >= state);
    last   = state == ALARM ? CNT_W'(ALARM_LEN - 1) :
             state == CHIME ? CNT_W'(CHIME_LEN - 1) : CNT_W'(CLICK_LEN - 1);
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    if (accept) begin
      state_n = req;
      cnt_n   = '0;
    end else if (state != IDLE && (bus.cancel || (bus.tick && cnt == last))) begin
      state_n = IDLE;
      cnt_n   = '0;
      done_n  = 1'b1;
    end else if (state != IDLE && bus.tick) begin
      cnt_n = cnt + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= done_n;
    end
  end
  // alarm beeps on even tick intervals; idle shows the set-mode blink cue
  assign bus.buzz       = state == ALARM ? ~cnt[0] : state == IDLE ? (bus.set_mode & bus.blink) : 1'b1;
  assign bus.busy       = state != IDLE;
  assign bus.active_src = state;
  assign bus.done       = done;
endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb_buzzer_arbiter: directed vectors against hand-computed buzzer arbiter behaviour
module tb_buzzer_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  buzzer_arbiter_if bus ();
  buzzer_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    bus.tick = 0; bus.alarm_req = 0; bus.chime_req = 0; bus.click_req = 0; bus.cancel = 0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1;
      step();
    end
  endtask
  initial begin
    bus.tick = 0; bus.alarm_req = 0; bus.chime_req = 0; bus.click_req = 0; bus.cancel = 0;
    bus.set_mode = 0; bus.blink = 0;
    #12;
    chk("rst_src", bus.active_src, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_buzz", bus.buzz, 0);
    rst_n = 1;
    step();
    // full alarm: beeping cadence, busy for exactly 30 tick intervals
    bus.alarm_req = 1;
    step();
    chk("al_src", bus.active_src, 3);
    for (int i = 0; i < 30; i++) begin
      chk($sformatf("al_buzz%0d", i), bus.buzz, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("al_busy%0d", i), bus.busy, 1);
      chk($sformatf("al_done%0d", i), bus.done, 0);
      bus.tick = 1;
      step();
    end
    chk("al_end_src", bus.active_src, 0);
    chk("al_end_done", bus.done, 1);
    chk("al_end_busy", bus.busy, 0);
    step();
    chk("al_done_once", bus.done, 0);
    // chime preempted by alarm, mid-alarm chime dropped
    bus.chime_req = 1;
    step();
    chk("ch_src", bus.active_src, 2);
    ticks(1);
    chk("ch_still", bus.active_src, 2);
    bus.alarm_req = 1;
    step();
    chk("pre_src", bus.active_src, 3);
    chk("pre_done", bus.done, 0);
    ticks(5);
    bus.chime_req = 1;
    step();
    chk("drop_chime", bus.active_src, 3);
    ticks(24);
    chk("pre_run29", bus.active_src, 3);
    chk("pre_run29_done", bus.done, 0);
    ticks(1);
    chk("pre_end_src", bus.active_src, 0);
    chk("pre_end_done", bus.done, 1);
    step();
    // simultaneous click and chime: chime wins
    bus.click_req = 1; bus.chime_req = 1;
    step();
    chk("sim_src", bus.active_src, 2);
    ticks(1);
    chk("sim_t1", bus.active_src, 2);
    chk("sim_t1_done", bus.done, 0);
    ticks(1);
    chk("sim_end_src", bus.active_src, 0);
    chk("sim_end_done", bus.done, 1);
    step();
    chk("sim_done_once", bus.done, 0);
    // cancel at counter 5
    bus.alarm_req = 1;
    step();
    ticks(5);
    chk("cn_buzz_odd", bus.buzz, 0);
    bus.cancel = 1;
    step();
    chk("cn_src", bus.active_src, 0);
    chk("cn_done", bus.done, 1);
    step();
    chk("cn_done_once", bus.done, 0);
    // cancel overridden by coincident alarm restart
    bus.alarm_req = 1;
    step();
    ticks(5);
    bus.alarm_req = 1; bus.cancel = 1;
    step();
    chk("ov_src", bus.active_src, 3);
    chk("ov_done", bus.done, 0);
    chk("ov_buzz_cnt0", bus.buzz, 1);
    ticks(1);
    chk("ov_buzz_cnt1", bus.buzz, 0);
    // dropped chime does not block cancel; cancel with tick gives a single done
    bus.chime_req = 1; bus.cancel = 1; bus.tick = 1;
    step();
    chk("dc_src", bus.active_src, 0);
    chk("dc_done", bus.done, 1);
    step();
    chk("dc_done_once", bus.done, 0);
    bus.cancel = 1;
    step();
    chk("idle_cancel", bus.done, 0);
    // idle blink cue and key click
    bus.set_mode = 1; bus.blink = 1;
    #1;
    chk("blink_on", bus.buzz, 1);
    bus.blink = 0;
    #1;
    chk("blink_off", bus.buzz, 0);
    bus.set_mode = 0; bus.blink = 1;
    #1;
    chk("no_set", bus.buzz, 0);
    bus.click_req = 1;
    step();
    chk("ck_src", bus.active_src, 1);
    chk("ck_buzz", bus.buzz, 1);
    step();
    chk("ck_hold", bus.buzz, 1);
    ticks(1);
    chk("ck_end_src", bus.active_src, 0);
    chk("ck_end_done", bus.done, 1);
    chk("ck_end_buzz", bus.buzz, 0);
    step();
    // asynchronous reset mid-chime
    bus.chime_req = 1;
    step();
    ticks(1);
    chk("rs_pre", bus.active_src, 2);
    #2;
    rst_n = 0;
    #1;
    chk("rs_src", bus.active_src, 0);
    chk("rs_busy", bus.busy, 0);
    chk("rs_buzz", bus.buzz, 0);
    chk("rs_done", bus.done, 0);
    step();
    rst_n = 1;
    step();
    chk("rs_after_done", bus.done, 0);
    step();
    chk("rs_after_done2", bus.done, 0);
    chk("rs_after_src", bus.active_src, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
